// File: rtl/text_console_writer_pkg.sv
// Shared constants, control codes and FSM encoding for the text console writer.
// Optional feature macro used by the top: TEXT_CONSOLE_CLEAR_ON_RESET_EN.
package text_console_defs;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row counters plus the running row base address (row*COLS kept
// incrementally so no multiplier is needed).
module text_cursor #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              newline,
  input  logic              cr,
  input  logic              back,
  input  logic              home,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_row_base
);

  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

  logic [ADDR_W-1:0] row_base;
  logic [4:0]        next_row;

  assign next_row      = (row == LAST_ROW) ? '0 : row + 5'd1;
  assign next_row_base = (row_base == LAST_BASE) ? '0 : row_base + ROW_STEP;
  assign addr          = row_base + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (!rst_n || home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (newline || (advance && col == LAST_COL)) begin
      col      <= '0;
      row      <= next_row;
      row_base <= next_row_base;
    end else if (advance) begin
      col <= col + 7'd1;
    end else if (cr) begin
      col <= '0;
    end else if (back && col != 7'd0) begin
      col <= col - 7'd1;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream console writer driving port A of the text memory.
// Define TEXT_CONSOLE_CLEAR_ON_RESET_EN to blank the whole screen after reset.
module text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  import text_console_defs::*;

  localparam int                CELL_CNT  = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(CELL_CNT - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
  localparam state_e RESET_STATE = ST_CLR_ALL;
  localparam logic   RESET_PEND  = 1'b1;
`else
  localparam state_e RESET_STATE = ST_READY;
  localparam logic   RESET_PEND  = 1'b0;
`endif

  state_e            state;
  logic              clr_pend;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] nl_base;
  logic              xfer;
  logic              do_prt, do_lf, do_cr, do_bs, do_ff;

  assign xfer   = in_valid && in_ready;
  assign do_prt = xfer && is_printable(in_data);
  assign do_lf  = xfer && (in_data == CHR_LF);
  assign do_cr  = xfer && (in_data == CHR_CR);
  assign do_bs  = xfer && (in_data == CHR_BS);
  assign do_ff  = xfer && (in_data == CHR_FF);

  text_cursor #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) u_cursor (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (do_prt),
    .newline      (do_lf),
    .cr           (do_cr),
    .back         (do_bs),
    .home         (do_ff),
    .col          (cursor_col),
    .row          (cursor_row),
    .addr         (cur_addr),
    .next_row_base(nl_base)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      clr_pend <= RESET_PEND;
      clr_cnt  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_READY: begin
          in_ready <= 1'b1;
          if (do_prt) begin
            mem_we   <= 1'b1;
            mem_addr <= cur_addr;
            mem_din  <= in_data;
            // Wrapping off the last column: the char write goes out first,
            // the new row is blanked starting in the following cycle.
            if (cursor_col == LAST_COL) begin
              state    <= ST_CLR_LINE;
              clr_pend <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end else if (do_lf || do_ff) begin
            mem_we   <= 1'b1;
            mem_addr <= do_lf ? nl_base : '0;
            mem_din  <= BLANK_CHAR;
            clr_cnt  <= '0;
            state    <= do_lf ? ST_CLR_LINE : ST_CLR_ALL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else if (do_bs && cursor_col != 7'd0) begin
            mem_we   <= 1'b1;
            mem_addr <= cur_addr - ADDR_W'(1);
            mem_din  <= BLANK_CHAR;
          end
        end
        ST_CLR_LINE, ST_CLR_ALL: begin
          if (clr_pend) begin
            // Cursor column is 0 here, so cur_addr is the row base.
            mem_we   <= 1'b1;
            mem_addr <= (state == ST_CLR_ALL) ? '0 : cur_addr;
            mem_din  <= BLANK_CHAR;
            clr_cnt  <= '0;
            clr_pend <= 1'b0;
            busy     <= 1'b1;
          end else if (clr_cnt == ((state == ST_CLR_ALL) ? ALL_LAST : LINE_LAST)) begin
            state    <= ST_READY;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(1);
            clr_cnt  <= clr_cnt + ADDR_W'(1);
          end
        end
        default: begin
          state    <= ST_READY;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Randomized self-checking bench for text_console_writer against a
// screen-level reference model (cursor position plus expected write list).
module tb_text_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: cursor and the ordered list of expected memory writes,
  // each tagged with the cycle it must appear in.
  typedef struct {
    int addr;
    int data;
    int due;
    bit clr;
  } wr_t;

  wr_t exp_q[$];
  int  m_col = 0;
  int  m_row = 0;

  function automatic void push_wr(input int a, input int d, input int due, input bit c);
    wr_t w;
    w.addr = a; w.data = d; w.due = due; w.clr = c;
    exp_q.push_back(w);
  endfunction

  // t = cycle in which a write caused by this transfer would appear
  function automatic void model_byte(input logic [7:0] b, input int t);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, int'(b), t, 1'b0);
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 32, t + 1 + i, 1'b1);
      end
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 32, t + i, 1'b1);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row * COLS + m_col, 32, t, 1'b0);
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      for (int i = 0; i < CELLS; i++) push_wr(i, 32, t + i, 1'b1);
    end
  endfunction

  int  busy_cnt = 0;
  wr_t mon_w;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {20'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", {20'd0, mem_addr}, mon_w.addr);
        check("wr_data", {24'd0, mem_din}, mon_w.data);
        check("wr_cycle", cyc, mon_w.due);
        if (mon_w.clr) begin
          check("clr_busy", {31'd0, busy}, 1);
          check("clr_in_ready", {31'd0, in_ready}, 0);
        end
      end
    end
  end

  // Called away from the clock edge; returns one time unit after the
  // transfer edge with in_valid left high when hold is set.
  task automatic send(input logic [7:0] b, input bit hold);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_timeout", {31'd0, (n < LIMIT)}, 1);
    @(posedge clk);
    #1;
    model_byte(b, cyc);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((in_ready !== 1'b1 || exp_q.size() != 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, (n < LIMIT)}, 1);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, {25'd0, cursor_col}, m_col);
    check({tag, "_row"}, {27'd0, cursor_row}, m_row);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32'h20, 32'h7E));
    if (r < 76) return 8'h0A;
    if (r < 82) return 8'h0D;
    if (r < 90) return 8'h08;
    if (r < 95) return 8'($urandom_range(0, 7));
    return 8'($urandom_range(32'h7F, 32'hFF));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int mark;
  int n;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_mem_we",   {31'd0, mem_we}, 0);
    check("rst_mem_addr", {20'd0, mem_addr}, 0);
    check("rst_mem_din",  {24'd0, mem_din}, 0);
    check("rst_busy",     {31'd0, busy}, 0);
    check_cursor("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "A","B" back to back
    send(8'h41, 1'b1);
    send(8'h42, 1'b0);
    wait_idle();
    check_cursor("ab");

    // full row of printables from (0,0), then the line clear of row 1
    send(8'h0D, 1'b0);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32'h21, 32'h7E)), i != COLS - 1);
    wait_idle();
    check_cursor("row_fill");

    // LF from (5,29) wraps to row 0
    for (int i = 0; i < 28; i++) send(8'h0A, 1'b0);
    wait_idle();
    for (int i = 0; i < 5; i++) send(8'h2E, i != 4);
    wait_idle();
    check_cursor("pre_wrap");
    mark = busy_cnt;
    send(8'h0A, 1'b0);
    wait_idle();
    check("lf_busy_cycles", busy_cnt - mark, COLS);
    check_cursor("lf_wrap");

    // backspace at (3,2) and at (0,2)
    send(8'h0A, 1'b0);
    send(8'h0A, 1'b0);
    wait_idle();
    send(8'h78, 1'b1);
    send(8'h79, 1'b1);
    send(8'h7A, 1'b0);
    send(8'h08, 1'b0);
    wait_idle();
    check_cursor("bs_mid");
    send(8'h0D, 1'b0);
    send(8'h08, 1'b0);
    repeat (3) @(negedge clk);
    check_cursor("bs_col0");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      send(rand_byte(), (i % 50 != 49) && ($urandom_range(0, 1) == 1));
      if (i % 50 == 49) begin
        wait_idle();
        check_cursor("rand");
      end
    end

    // form feed mid-screen
    wait_idle();
    mark = busy_cnt;
    send(8'h0C, 1'b0);
    wait_idle();
    check("ff_busy_cycles", busy_cnt - mark, CELLS);
    check("ff_in_ready", {31'd0, in_ready}, 1);
    check_cursor("ff");

    // reset in the middle of a full clear
    send(8'h41, 1'b0);
    send(8'h0A, 1'b0);
    wait_idle();
    send(8'h0C, 1'b0);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 12'd1000) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("clr_reach_1000", {31'd0, (n < LIMIT)}, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    check("midrst_mem_we", {31'd0, mem_we}, 0);
    check("midrst_busy",   {31'd0, busy}, 0);
    check_cursor("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    check("post_rst_busy",     {31'd0, busy}, 0);
    check("post_rst_mem_we",   {31'd0, mem_we}, 0);

    // post-reset traffic resumes at (0,0)
    send(8'h51, 1'b0);
    wait_idle();
    check_cursor("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
